// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: clock inhibit, request-to-send, 11-bit frame
// clocked out by the device, ACK sampling, then wait for the bus to go idle.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES   = 6000,
  parameter int REQ_SETUP_CYCLES = 50,
  parameter int TIMEOUT_CYCLES   = 750000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       send,
  input  logic [7:0] tx_data,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       done,
  output logic       error
);

  // state     | meaning
  // IDLE      | both lines released, waiting for send
  // INHIBIT   | host holds PS/2 clock low
  // REQUEST   | clock and data low (start bit) before clock release
  // SHIFT     | device clocks out d0..d7, parity, stop
  // ACK       | wait for 11th falling edge, sample device ACK
  // WAIT_IDLE | wait for clock and data both high, then report
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    REQUEST   = 3'd2,
    SHIFT     = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  localparam int PH_MAX = (INHIBIT_CYCLES > REQ_SETUP_CYCLES) ? INHIBIT_CYCLES : REQ_SETUP_CYCLES;
  localparam int PW     = $clog2(PH_MAX + 1);
  localparam int WW     = $clog2(TIMEOUT_CYCLES + 1);

  state_t        state;
  logic [9:0]    shreg;
  logic [3:0]    bit_cnt;
  logic [PW-1:0] phase_cnt;
  logic [WW-1:0] wdog;
  logic          ack_ok;

  logic [1:0] clk_sync;
  logic [1:0] dat_sync;
  logic       clk_prev;
  logic       clk_s;
  logic       dat_s;
  logic       fe;
  logic       wd_active;
  logic       line_idle;
  logic       wd_expire;

  // Sync flops reset to the idle-high bus level so reset never fakes an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk_in};
      dat_sync <= {dat_sync[0], ps2_dat_in};
      clk_prev <= clk_sync[1];
    end
  end

  assign clk_s     = clk_sync[1];
  assign dat_s     = dat_sync[1];
  assign fe        = clk_prev & ~clk_s;
  assign busy      = (state != IDLE);
  assign wd_active = (state == SHIFT) || (state == ACK) || (state == WAIT_IDLE);
  assign line_idle = clk_s & dat_s;
  // A completing WAIT_IDLE wins over an expiring watchdog so done/error stay exclusive.
  assign wd_expire = wd_active && !fe && (wdog == '0) && !((state == WAIT_IDLE) && line_idle);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      phase_cnt  <= '0;
      wdog       <= '0;
      ack_ok     <= 1'b0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        IDLE: begin
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
          if (send && !done && !error) begin
            shreg      <= {1'b1, ~^tx_data, tx_data};
            bit_cnt    <= '0;
            wdog       <= '0;
            phase_cnt  <= PW'(INHIBIT_CYCLES - 1);
            ps2_clk_oe <= 1'b1;
            state      <= INHIBIT;
          end
        end

        INHIBIT: begin
          if (phase_cnt == '0) begin
            phase_cnt  <= PW'(REQ_SETUP_CYCLES - 1);
            ps2_dat_oe <= 1'b1;
            state      <= REQUEST;
          end else begin
            phase_cnt <= phase_cnt - 1'b1;
          end
        end

        REQUEST: begin
          if (phase_cnt == '0) begin
            ps2_clk_oe <= 1'b0;
            bit_cnt    <= '0;
            wdog       <= WW'(TIMEOUT_CYCLES - 1);
            state      <= SHIFT;
          end else begin
            phase_cnt <= phase_cnt - 1'b1;
          end
        end

        SHIFT: begin
          if (fe) begin
            bit_cnt    <= bit_cnt + 4'd1;
            ps2_dat_oe <= ~shreg[bit_cnt];
            wdog       <= WW'(TIMEOUT_CYCLES - 1);
            if (bit_cnt == 4'd9) state <= ACK;
          end else begin
            wdog <= wdog - 1'b1;
          end
        end

        ACK: begin
          ps2_dat_oe <= 1'b0;
          if (fe) begin
            ack_ok <= ~dat_s;
            wdog   <= WW'(TIMEOUT_CYCLES - 1);
            state  <= WAIT_IDLE;
          end else begin
            wdog <= wdog - 1'b1;
          end
        end

        WAIT_IDLE: begin
          if (line_idle) begin
            done  <= ack_ok;
            error <= ~ack_ok;
            state <= IDLE;
          end else if (fe) begin
            wdog <= WW'(TIMEOUT_CYCLES - 1);
          end else begin
            wdog <= wdog - 1'b1;
          end
        end

        default: begin
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
          state      <= IDLE;
        end
      endcase

      if (wd_expire) begin
        ps2_clk_oe <= 1'b0;
        ps2_dat_oe <= 1'b0;
        error      <= 1'b1;
        state      <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx with an open-collector PS/2 device model
// that clocks at a 40-cycle period and optionally ACKs, NACKs or stays silent.
`timescale 1ns/1ps
module tb_ps2_host_tx;
  localparam int INH = 20;
  localparam int REQ = 4;
  localparam int TO  = 200;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       send = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       ps2_clk_line, ps2_dat_line;
  logic       ps2_clk_oe, ps2_dat_oe, busy, done, error;

  assign ps2_clk_line = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_line = dev_dat & ~ps2_dat_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES  (INH),
    .REQ_SETUP_CYCLES(REQ),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .send      (send),
    .tx_data   (tx_data),
    .ps2_clk_in(ps2_clk_line),
    .ps2_dat_in(ps2_dat_line),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          exp_done;
    bit          chk_frame;
    logic [10:0] frame;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  int          dev_mode = 0;   // 0 ACK, 1 NACK, 2 silent
  int          dev_falls = 0;
  logic [10:0] cap = '0;       // {stop, parity, d7..d0, start}
  bit          cap_valid = 1'b0;
  bit          prev_busy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Device: on request (clock released, data low) capture start, clock 11 times.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && !ps2_clk_oe && ps2_dat_oe && dev_mode != 2) begin
        cap_valid = 1'b0;
        dev_falls = 0;
        cap[0] = ps2_dat_line;
        repeat (10) @(negedge clk);
        for (int k = 1; k <= 11; k++) begin
          dev_clk = 1'b0;
          dev_falls++;
          repeat (20) @(negedge clk);
          if (k <= 10) cap[k] = ps2_dat_line;
          dev_clk = 1'b1;
          if (k == 10) cap_valid = 1'b1;
          if (k == 10 && dev_mode == 0) begin
            repeat (10) @(negedge clk);
            dev_dat = 1'b0;
            repeat (10) @(negedge clk);
          end else begin
            repeat (20) @(negedge clk);
          end
        end
        dev_dat = 1'b1;
      end
    end
  end

  // Monitor: every done/error pulse consumes one expected outcome.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done || error) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: done=%0b error=%0b, expected no pulse", done, error);
        end else begin
          e = sbq.pop_front();
          chk("done", done, e.exp_done);
          chk("error", error, !e.exp_done);
          chk("busy_at_pulse", busy, 0);
          chk("busy_before_pulse", prev_busy, 1);
          chk("oe_at_pulse", {ps2_clk_oe, ps2_dat_oe}, 0);
          if (e.chk_frame) begin
            chk("frame_captured", cap_valid, 1);
            chk("frame", cap, e.frame);
          end
        end
      end
      prev_busy = busy;
    end
  end

  task automatic do_send(input logic [7:0] d, input bit push, input bit exp_done,
                         input bit chk_frame, input logic [10:0] frame);
    exp_t e;
    @(negedge clk);
    send    = 1'b1;
    tx_data = d;
    if (push) begin
      e.exp_done  = exp_done;
      e.chk_frame = chk_frame;
      e.frame     = frame;
      sbq.push_back(e);
    end
    @(negedge clk);
    send    = 1'b0;
    tx_data = ~d;
  endtask

  task automatic wait_not_busy(input string name);
    int n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: busy still 1 after %0d cycles, expected 0", name, n);
    end
    repeat (3) @(negedge clk);
    chk({name, "_sb_empty"}, sbq.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_clk_oe", ps2_clk_oe, 0);
    chk("rst_dat_oe", ps2_dat_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // 0xED: inhibit/request timing, then ACKed frame
    do_send(8'hED, 1, 1, 1, {1'b1, 1'b1, 8'hED, 1'b0});
    n = 0;
    while (ps2_clk_oe && !ps2_dat_oe && n < 100) begin n++; @(negedge clk); end
    chk("inhibit_cycles", n, INH);
    n = 0;
    while (ps2_clk_oe && ps2_dat_oe && n < 100) begin n++; @(negedge clk); end
    chk("request_cycles", n, REQ);
    chk("start_bit_held", ps2_dat_oe, 1);
    wait_not_busy("ed");

    do_send(8'hF4, 1, 1, 1, {1'b1, 1'b0, 8'hF4, 1'b0});
    wait_not_busy("f4");
    do_send(8'h00, 1, 1, 1, {1'b1, 1'b1, 8'h00, 1'b0});
    wait_not_busy("00");

    // NACK: data stays high on the 11th clock
    dev_mode = 1;
    do_send(8'hAB, 1, 0, 1, {1'b1, 1'b0, 8'hAB, 1'b0});
    wait_not_busy("nack");
    dev_mode = 0;

    // Silent device: watchdog fires TO cycles after SHIFT entry
    dev_mode = 2;
    do_send(8'hF4, 1, 0, 0, '0);
    n = 0;
    while (ps2_clk_oe && n < 100) begin n++; @(negedge clk); end
    n = 0;
    while (!error && n < 400) begin @(negedge clk); n++; end
    chk("timeout_latency", n, TO);
    wait_not_busy("timeout");
    dev_mode = 0;

    // Second send during INHIBIT is ignored
    do_send(8'h12, 1, 1, 1, {1'b1, 1'b1, 8'h12, 1'b0});
    repeat (4) @(negedge clk);
    send    = 1'b1;
    tx_data = 8'h55;
    @(negedge clk);
    send    = 1'b0;
    chk("busy_after_ignored_send", busy, 1);
    n = 0;
    while (ps2_clk_oe && !ps2_dat_oe && n < 100) begin n++; @(negedge clk); end
    chk("inhibit_not_restarted", n, INH - 5);
    wait_not_busy("ignored");

    // Reset mid-SHIFT after the 4th falling edge
    do_send(8'h96, 0, 0, 0, '0);
    n = 0;
    while (dev_falls != 4 && n < 1000) begin @(negedge clk); n++; end
    chk("fe4_reached", dev_falls, 4);
    repeat (8) @(negedge clk);
    chk("pre_reset_dat_oe", ps2_dat_oe, 1);
    chk("pre_reset_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_clk_oe", ps2_clk_oe, 0);
    chk("async_rst_dat_oe", ps2_dat_oe, 0);
    chk("async_rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (500) @(negedge clk);
    do_send(8'hFF, 1, 1, 1, {1'b1, 1'b1, 8'hFF, 1'b0});
    wait_not_busy("ff");

    chk("final_sb_empty", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
